// File: rtl/skid_reg_if.sv
// rtl/skid_reg_if.sv - valid/ready/data stream bundle used on both sides of skid_reg

interface skid_reg_if #(
  parameter int DATA_W = 21
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  // Producer side drives valid/data and observes ready
  modport master (
    output valid,
    output data,
    input  ready
  );

  // Consumer side observes valid/data and drives ready
  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/skid_reg.sv
// rtl/skid_reg.sv - two-entry valid/ready skid buffer with registered ready

module skid_reg #(
  parameter int               DATA_W  = 21,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
  input  logic        clk_i,
  input  logic        cke_i,
  input  logic        arst_i,
  input  logic        rst_i,
  skid_reg_if.slave   s_if,
  skid_reg_if.master  m_if,
  output logic [1:0]  level_o
);

  // EMPTY: nothing held. BUSY: main register valid. FULL: main and skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_m_valid;
  logic              r_s_ready;
  logic [1:0]        r_level;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;

  // Qualified transfers; ready and valid come from registers only, so
  // s_ready has no combinational path from the downstream ready.
  logic w_in;
  logic w_out;

  assign w_in  = s_if.valid & r_s_ready & cke_i;
  assign w_out = r_m_valid & m_if.ready & cke_i;

  assign s_if.ready = r_s_ready;
  assign m_if.valid = r_m_valid;
  assign m_if.data  = r_main;
  assign level_o    = r_level;

  // Occupancy state machine; all outputs are registered alongside the state
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state   <= ST_EMPTY;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b1;
      r_level   <= 2'd0;
      r_main    <= RST_VAL;
      r_skid    <= RST_VAL;
    end else if (rst_i) begin
      // Flush wins over the clock enable and voids any transfer this cycle
      r_state   <= ST_EMPTY;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b1;
      r_level   <= 2'd0;
      r_main    <= RST_VAL;
      r_skid    <= RST_VAL;
    end else if (cke_i) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in) begin
            r_main    <= s_if.data;
            r_state   <= ST_BUSY;
            r_m_valid <= 1'b1;
            r_s_ready <= 1'b1;
            r_level   <= 2'd1;
          end
        end
        ST_BUSY: begin
          if (w_in && w_out) begin
            // Pass-through: new word replaces the one being consumed
            r_main <= s_if.data;
          end else if (w_in) begin
            // Consumer stalled: park the new word and stop accepting
            r_skid    <= s_if.data;
            r_state   <= ST_FULL;
            r_m_valid <= 1'b1;
            r_s_ready <= 1'b0;
            r_level   <= 2'd2;
          end else if (w_out) begin
            // main keeps its stale value; consumers ignore it while empty
            r_state   <= ST_EMPTY;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_level   <= 2'd0;
          end
        end
        ST_FULL: begin
          // Upstream is held off here, so only a read can move the state
          if (w_out) begin
            r_main    <= r_skid;
            r_state   <= ST_BUSY;
            r_m_valid <= 1'b1;
            r_s_ready <= 1'b1;
            r_level   <= 2'd1;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty state
          r_state   <= ST_EMPTY;
          r_m_valid <= 1'b0;
          r_s_ready <= 1'b1;
          r_level   <= 2'd0;
        end
      endcase
    end
  end

endmodule
